// File: rtl/data_memory_ctrl.sv
// Data-segment memory: base-relative byte-addressed word RAM with byte-enable writes,
// req/ready handshake, 1- or 2-cycle read pipeline and a zero-fill sequencer.
//
// state    | meaning
// ST_CLEAR | FSM owns the port, writes 0 to word[clr_cnt] each cycle
// ST_READY | services load/store requests, clr_i starts a new zero-fill
module data_memory_ctrl #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter int                    READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    ready_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   q_o,
  output logic                    err_o
);

  localparam int NUM_BYTES  = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(NUM_BYTES);
  localparam int IDX_W      = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NUM_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(MEMORY_DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(MEMORY_DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state;
  logic [IDX_W-1:0]      clr_cnt;
  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [IDX_W-1:0]      idx;
  logic                  addr_ok;
  logic                  accept;
  logic                  acc_wr;
  logic                  acc_rd;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  out_vld;
  logic                  out_err;
  logic [DATA_WIDTH-1:0] out_data;

  assign ready_o = (state == ST_READY) && !clr_i;
  assign accept  = req_i && ready_o;
  assign acc_wr  = accept && we_i;
  assign acc_rd  = accept && !we_i;

  // The full-width word offset is range-checked so addresses far above the
  // segment cannot alias into it through index truncation.
  assign off      = addr_i - BASE_ADDR;
  assign word_off = off >> BYTE_SHIFT;
  assign idx      = word_off[IDX_W-1:0];
  assign addr_ok  = (addr_i >= BASE_ADDR) && (word_off < DEPTH_A) &&
                    ((off & ALIGN_MASK) == '0);

  assign rd_word = addr_ok ? mem[idx] : '0;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_vld;
      logic                  s1_err;
      logic [DATA_WIDTH-1:0] s1_data;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_vld  <= 1'b0;
          s1_err  <= 1'b0;
          s1_data <= '0;
        end else begin
          s1_vld <= acc_rd;
          s1_err <= acc_rd && !addr_ok;
          if (acc_rd) s1_data <= rd_word;
        end
      end

      assign out_vld  = s1_vld;
      assign out_err  = s1_err;
      assign out_data = s1_data;
    end else begin : g_lat1
      assign out_vld  = acc_rd;
      assign out_err  = acc_rd && !addr_ok;
      assign out_data = rd_word;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_CLEAR;
      clr_cnt  <= '0;
      rvalid_o <= 1'b0;
      q_o      <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= out_vld;
      err_o    <= (out_vld && out_err) || (acc_wr && !addr_ok);
      if (out_vld) q_o <= out_data;

      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + IDX_W'(1);
          if (clr_cnt == LAST_IDX) state <= ST_READY;
        end
        ST_READY: begin
          if (clr_i) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Storage has no reset; the zero-fill sequence initialises it.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (acc_wr && addr_ok) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= data_i[8*k +: 8];
      end
    end
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised data-memory block for the processor memory system. It wraps a synchronous word RAM and adds:
- a byte-addressed, base-relative address map;
- byte-enable writes;
- a req/ready handshake;
- a configurable read pipeline latency;
- an automatic zero-fill state machine after reset or on request.

It sits between the datapath load/store unit and the data segment storage.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 32, byte address width.
MEMORY_DEPTH, 64, number of words stored.
READ_LATENCY, 1, cycles from accepted read to rvalid_o; legal values are 1 or 2.
BASE_ADDR, 32'h1001_0000, byte address of word 0.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
clr_i  input  1  request a zero-fill of the whole memory.
req_i  input  1  access request.
we_i  input  1  1 = write, 0 = read; sampled with req_i.
be_i  input  DATA_WIDTH/8  byte enables for writes; bit k covers data bits [8k+7:8k].
addr_i  input  ADDR_WIDTH  byte address.
data_i  input  DATA_WIDTH  write data.
ready_o  output  1  block can accept a request this cycle.
rvalid_o  output  1  q_o holds valid read data (1-cycle pulse per read).
q_o  output  DATA_WIDTH  read data.
err_o  output  1  1-cycle pulse for a rejected (out-of-range or misaligned) access.

Behaviour:
- Reset (reset=0, asynchronous): state=CLEAR, clear counter=0, ready_o=0, rvalid_o=0, q_o=0, err_o=0, read pipeline flushed.
- FSM states:
  - CLEAR: writes 0 to word[counter] each cycle, counter increments. After word MEMORY_DEPTH-1 is written, goes to READY. CLEAR lasts exactly MEMORY_DEPTH cycles.
  - READY: services requests. clr_i=1 moves the FSM to CLEAR (counter reset to 0) on the next edge. clr_i is ignored while in CLEAR.
- ready_o = (state==READY) && !clr_i, combinational.
- A transfer occurs on a rising edge when req_i && ready_o. Requests without ready_o are not accepted; the requester holds them.
- Address decode:
  - off = addr_i - BASE_ADDR;
  - index = off >> log2(DATA_WIDTH/8).
  - The access is invalid if addr_i < BASE_ADDR, or index >= MEMORY_DEPTH, or the low log2(DATA_WIDTH/8) bits of off are nonzero.
- Write, valid: only bytes with be_i[k]=1 are updated; other bytes are unchanged. be_i=0 is a legal no-op. The new data is visible to a read accepted on the next cycle.
- Write, invalid: memory is unchanged; err_o pulses the cycle after acceptance.
- Read:
  - Fully pipelined; one read can be accepted per cycle.
  - rvalid_o pulses exactly READ_LATENCY cycles after acceptance.
  - q_o is updated only on that rvalid cycle and holds its value otherwise.
  - Invalid read: still produces the rvalid_o pulse with q_o=0, and err_o pulses in the same cycle as that rvalid_o.
- Reads in flight when clr_i is taken complete normally with their pre-clear data.
- Reset asserted mid-CLEAR or mid-read: everything returns to reset values; the full clear restarts after reset is released; in-flight reads are dropped with no rvalid.
- Single port: at most one access per cycle. During CLEAR the port is owned by the FSM.

Test Plan:
1. Reset release with MEMORY_DEPTH=64 -> ready_o=0 for exactly 64 cycles, then 1. Reading 0x10010000 and 0x100100FC returns 0.
2. Write 0x55555555 to 0x10010000 with be=4'hF. Then write 0x00ABCDEF to 0x10010008 with be=4'b0101. Read both -> 0x55555555 and 0x00AB00EF. With READ_LATENCY=1, rvalid_o rises 1 cycle after acceptance.
3. READ_LATENCY=2: write 0x17283946, 0x30303030, 0x1234ABCD to words 3, 4, 5. Issue back-to-back reads of 3, 4, 5 on consecutive cycles -> rvalid_o high for 3 consecutive cycles starting 2 cycles after the first accept, with data in order.
4. Invalid accesses: write 0xFFFFFFFF to 0x10010100 (index 64), 0x10010002 (misaligned), and 0x1000FFFC (below base) -> err_o pulses each time and memory is unchanged. A read of 0x10010100 -> rvalid_o=1, q_o=0, err_o=1 in the same cycle.
5. clr_i=1 together with req_i=1 while in READY -> request not accepted, ready_o low for 64 cycles. Afterwards, word 0 (previously 0x55555555) reads 0. A read accepted one cycle before clr_i still returns the old data.
6. Assert reset at clear cycle 20 for 3 cycles -> outputs are zero immediately (asynchronous). After release, ready_o stays low for a full 64 cycles.
